if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter: PC_RESET, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble.
REQ-003 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_i  input  1  reset, asynchronous, active-low.
REQ-005 Port: stall_i  input  1  hazard unit requests hold of PC and IF/ID.
REQ-006 Port: redirect_i  input  1  taken branch/jump; flush and load target.
REQ-007 Port: target_i  input  32  redirect target address.
REQ-008 Port: imem_addr_o  output  32  byte address to instruction memory, equal to current PC.
REQ-009 Port: imem_instr_i  input  32  combinational instruction word returned for imem_addr_o.
REQ-010 Port: ifid_instr_o  output  32  IF/ID registered instruction.
REQ-011 Port: ifid_pc4_o  output  32  IF/ID registered PC+4 of that instruction.
REQ-012 Port: ifid_valid_o  output  1  IF/ID holds a real (non-bubble) instruction.

Function
REQ-013 imem_addr_o SHALL equal the PC register combinationally, no added latency.
REQ-014 Normal cycle (no stall, no redirect): PC <= PC+4; IF/ID <= {imem_instr_i, PC+4, valid=1}.
REQ-015 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no overflow flag.
REQ-016 Stall only: PC and all IF/ID fields SHALL hold their values.
REQ-017 Redirect: PC <= {target_i[31:2],2'b00}; IF/ID <= {NOP_INSTR, 32'h0, valid=0}.
REQ-018 Redirect and stall in same cycle: redirect SHALL win; stall ignored that cycle.
REQ-019 Misaligned target_i: low two bits SHALL be forced to zero; no exception.
REQ-020 Fetch state machine, two states: RESET_FILL (after reset, IF/ID invalid) and RUN; RESET_FILL -> RUN on first edge with no stall; stall in RESET_FILL keeps RESET_FILL; redirect from either state -> RUN with bubble.
REQ-021 Instruction captured is from the cycle's PC; effective fetch-to-IF/ID latency is exactly one cycle.
REQ-022 Outputs SHALL be driven only from registers except imem_addr_o (= PC register).

Reset
REQ-023 On rst_i low, asynchronously: PC=PC_RESET, ifid_instr_o=NOP_INSTR, ifid_pc4_o=0, ifid_valid_o=0, state=RESET_FILL, counters=0.
REQ-024 Reset mid-stall or mid-redirect SHALL discard pending action; first post-reset fetch address is PC_RESET.
REQ-025 Release of rst_i SHALL take effect on the next rising edge without glitch on outputs.

Configuration
REQ-026 Macro IF_FETCH_PERF_CNT_EN: when defined, add outputs fetch_cnt_o (32) counting edges executing REQ-014, and bubble_cnt_o (32) counting edges executing REQ-017 or REQ-016; both wrap modulo 2^32, reset to 0.
REQ-027 When IF_FETCH_PERF_CNT_EN is undefined, the counter ports and logic SHALL not exist; all other behaviour identical.

Structure
REQ-028 Shared package cpu_pkg SHALL hold: data width 32, NOP_INSTR default, fetch state enum {RESET_FILL, RUN}.
REQ-029 Counters SHALL be a sub-module fetch_perf_cnt instantiated only under IF_FETCH_PERF_CNT_EN.
REQ-030 Next-PC selection and IF/ID register SHALL reside in if_fetch_stage itself.

Verification
REQ-031 Reset release, memory returns word at addr/4, 3 free cycles -> imem_addr_o 0,4,8,12; ifid_pc4_o 4,8,12; valid=1 from cycle 1.
REQ-032 Stall for 2 cycles at PC=8 -> imem_addr_o stays 8, IF/ID holds pc4=8 word; resumes with PC 12.
REQ-033 Redirect target 32'h0000_0042 at PC=16 -> next PC=32'h40, IF/ID = NOP_INSTR, valid=0, pc4=0; next cycle valid=1 pc4=32'h44.
REQ-034 Redirect and stall asserted together -> redirect behaviour of REQ-033, PC not held.
REQ-035 PC_RESET=32'hFFFF_FFFC, one free cycle -> PC=0, ifid_pc4_o=0, valid=1.
REQ-036 rst_i asserted between clock edges during stall -> outputs immediately at reset values; with IF_FETCH_PERF_CNT_EN, 5 fetches + 1 redirect + 2 stalls -> fetch_cnt_o=5, bubble_cnt_o=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch stage and its neighbours: datapath width,
// the default bubble instruction and the fetch state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 32;

    // All-zero word doubles as the bubble that downstream decode ignores.
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RESET_FILL = 1'b0,
        RUN        = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// if_fetch_stage_if
// Bundles the fetch stage's control inputs, instruction-memory bus and IF/ID
// register outputs.
//   stall_i       hazard unit hold request
//   redirect_i    taken branch/jump
//   target_i      redirect target address
//   imem_addr_o   byte address presented to instruction memory
//   imem_instr_i  combinational instruction word for imem_addr_o
//   ifid_instr_o  IF/ID instruction
//   ifid_pc4_o    IF/ID PC+4
//   ifid_valid_o  IF/ID holds a real instruction
// Modports: master = fetch stage, slave = its environment.
// ----------------------------------------------------------------------------
interface if_fetch_stage_if;
    import cpu_pkg::*;

    logic            stall_i;
    logic            redirect_i;
    logic [XLEN-1:0] target_i;
    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_instr_i;
    logic [XLEN-1:0] ifid_instr_o;
    logic [XLEN-1:0] ifid_pc4_o;
    logic            ifid_valid_o;

    modport master (
        input  stall_i, redirect_i, target_i, imem_instr_i,
        output imem_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o
    );

    modport slave (
        output stall_i, redirect_i, target_i, imem_instr_i,
        input  imem_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o
    );

endinterface

// File: rtl/fetch_perf_cnt.sv
// ----------------------------------------------------------------------------
// fetch_perf_cnt
// Free-running fetch and bubble event counters, wrapping modulo 2^32.
// Only built when IF_FETCH_PERF_CNT_EN is defined.
//   clk_i, rst_i      clock, asynchronous active-low reset
//   fetch_i           this edge performs a normal fetch
//   bubble_i          this edge stalls or redirects
//   fetch_cnt_o       count of fetch edges
//   bubble_cnt_o      count of stall/redirect edges
// ----------------------------------------------------------------------------
`ifdef IF_FETCH_PERF_CNT_EN
module fetch_perf_cnt
    import cpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fetch_i,
    input  logic            bubble_i,
    output logic [XLEN-1:0] fetch_cnt_o,
    output logic [XLEN-1:0] bubble_cnt_o
);

    logic [XLEN-1:0] fetch_cnt_q,  fetch_cnt_d;
    logic [XLEN-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q  + (fetch_i  ? 32'd1 : 32'd0);
        bubble_cnt_d = bubble_cnt_q + (bubble_i ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule
`endif

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction fetch: holds the PC, presents it to instruction memory and
// captures the returned word with its PC+4 into the IF/ID register.
// Redirect beats stall; a redirect loads the word-aligned target and inserts
// a bubble into IF/ID.
//   clk_i, rst_i   clock, asynchronous active-low reset
//   bus (master)   stall/redirect/target inputs, imem bus, IF/ID outputs
//   fetch_cnt_o, bubble_cnt_o   performance counters (IF_FETCH_PERF_CNT_EN)
// Optional feature macro: IF_FETCH_PERF_CNT_EN.
// ----------------------------------------------------------------------------
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
`ifdef IF_FETCH_PERF_CNT_EN
    output logic [XLEN-1:0] fetch_cnt_o,
    output logic [XLEN-1:0] bubble_cnt_o,
`endif
    if_fetch_stage_if.master bus
);

    localparam logic [0:0] ST_RESET_FILL = 1'(RESET_FILL);
    localparam logic [0:0] ST_RUN        = 1'(RUN);

    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q,   pc4_d;
    logic            valid_q, valid_d;
    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] pc_plus4;

    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        state_d = state_q;
        if (bus.redirect_i) begin
            // Redirect overrides any simultaneous stall.
            pc_d    = {bus.target_i[XLEN-1:2], 2'b00};
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (!bus.stall_i) begin
            pc_d    = pc_plus4;
            instr_d = bus.imem_instr_i;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q    <= PC_RESET;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            state_q <= ST_RESET_FILL;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign bus.imem_addr_o  = pc_q;
    assign bus.ifid_instr_o = instr_q;
    assign bus.ifid_pc4_o   = pc4_q;
    assign bus.ifid_valid_o = valid_q;

`ifdef IF_FETCH_PERF_CNT_EN
    logic fetch_evt;
    logic bubble_evt;

    assign fetch_evt  = !bus.redirect_i && !bus.stall_i;
    assign bubble_evt =  bus.redirect_i ||  bus.stall_i;

    fetch_perf_cnt u_perf_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fetch_i      (fetch_evt),
        .bubble_i     (bubble_evt),
        .fetch_cnt_o  (fetch_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = 32'h0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: distinct, nonzero word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ 32'hC0DE_0000;
    endfunction

    if_fetch_stage_if bus0();
    if_fetch_stage_if bus1();

    assign bus0.stall_i      = stall;
    assign bus0.redirect_i   = redirect;
    assign bus0.target_i     = target;
    assign bus0.imem_instr_i = mem_word(bus0.imem_addr_o);

    assign bus1.stall_i      = 1'b0;
    assign bus1.redirect_i   = 1'b0;
    assign bus1.target_i     = 32'h0;
    assign bus1.imem_instr_i = mem_word(bus1.imem_addr_o);

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] fcnt0, bcnt0, fcnt1, bcnt1;
`endif

    if_fetch_stage u_dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
`ifdef IF_FETCH_PERF_CNT_EN
        .fetch_cnt_o  (fcnt0),
        .bubble_cnt_o (bcnt0),
`endif
        .bus          (bus0)
    );

    if_fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
        .clk_i        (clk),
        .rst_i        (rst_n),
`ifdef IF_FETCH_PERF_CNT_EN
        .fetch_cnt_o  (fcnt1),
        .bubble_cnt_o (bcnt1),
`endif
        .bus          (bus1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: architectural PC, IF/ID contents and event counts.
    logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_bc;
    logic        m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
            m_fc <= 32'h0; m_bc <= 32'h0;
        end else if (redirect) begin
            m_pc <= target & ~32'd3; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
            m_bc <= m_bc + 1;
        end else if (stall) begin
            m_bc <= m_bc + 1;
        end else begin
            m_pc <= m_pc + 4; m_instr <= mem_word(m_pc); m_pc4 <= m_pc + 4; m_valid <= 1'b1;
            m_fc <= m_fc + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_addr",  bus0.imem_addr_o,  m_pc);
            check("model_instr", bus0.ifid_instr_o, m_instr);
            check("model_pc4",   bus0.ifid_pc4_o,   m_pc4);
            check("model_valid", {31'b0, bus0.ifid_valid_o}, {31'b0, m_valid});
`ifdef IF_FETCH_PERF_CNT_EN
            check("model_fcnt", fcnt0, m_fc);
            check("model_bcnt", bcnt0, m_bc);
`endif
        end
    end

    // Inputs change at posedge+1, far from the active edge.
    task automatic step(input logic s, input logic r, input logic [31:0] t);
        stall = s; redirect = r; target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_addr",  bus0.imem_addr_o,  32'h0);
        check("rst_instr", bus0.ifid_instr_o, 32'h0);
        check("rst_pc4",   bus0.ifid_pc4_o,   32'h0);
        check("rst_valid", {31'b0, bus0.ifid_valid_o}, 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
        check("rst_fcnt", fcnt0, 32'h0);
        check("rst_bcnt", bcnt0, 32'h0);
`endif
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        apply_reset();
        check("wrap_rst_addr", bus1.imem_addr_o, 32'hFFFF_FFFC);
        check("free0_addr", bus0.imem_addr_o, 32'h0);

        // Three free cycles from reset.
        step(0, 0, 0);
        check("free1_addr", bus0.imem_addr_o, 32'h4);
        check("free1_pc4", bus0.ifid_pc4_o, 32'h4);
        check("free1_instr", bus0.ifid_instr_o, 32'hC0DE_0000);
        check("free1_valid", {31'b0, bus0.ifid_valid_o}, 32'h1);
        check("wrap_addr", bus1.imem_addr_o, 32'h0);
        check("wrap_pc4", bus1.ifid_pc4_o, 32'h0);
        check("wrap_valid", {31'b0, bus1.ifid_valid_o}, 32'h1);
        step(0, 0, 0);
        check("free2_addr", bus0.imem_addr_o, 32'h8);
        check("free2_pc4", bus0.ifid_pc4_o, 32'h8);
        step(0, 0, 0);
        check("free3_addr", bus0.imem_addr_o, 32'hC);
        check("free3_pc4", bus0.ifid_pc4_o, 32'hC);

        // Stall two cycles at PC=8, resume, then redirect at PC=16.
        apply_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0);
            check("stall_addr", bus0.imem_addr_o, 32'h8);
            check("stall_pc4", bus0.ifid_pc4_o, 32'h8);
            check("stall_instr", bus0.ifid_instr_o, 32'hC0DE_0001);
        end
        step(0, 0, 0);
        check("resume_addr", bus0.imem_addr_o, 32'hC);
        check("resume_pc4", bus0.ifid_pc4_o, 32'hC);
        step(0, 0, 0);
        check("pre_redir_addr", bus0.imem_addr_o, 32'h10);
        step(0, 1, 32'h0000_0042);
        check("redir_addr", bus0.imem_addr_o, 32'h40);
        check("redir_instr", bus0.ifid_instr_o, 32'h0);
        check("redir_pc4", bus0.ifid_pc4_o, 32'h0);
        check("redir_valid", {31'b0, bus0.ifid_valid_o}, 32'h0);
        step(0, 0, 0);
        check("post_redir_valid", {31'b0, bus0.ifid_valid_o}, 32'h1);
        check("post_redir_pc4", bus0.ifid_pc4_o, 32'h44);
`ifdef IF_FETCH_PERF_CNT_EN
        check("cnt_fetch5", fcnt0, 32'd5);
        check("cnt_bubble3", bcnt0, 32'd3);
`endif

        // Redirect together with stall, misaligned target.
        step(1, 1, 32'h0000_0103);
        check("rs_addr", bus0.imem_addr_o, 32'h100);
        check("rs_valid", {31'b0, bus0.ifid_valid_o}, 32'h0);
        check("rs_pc4", bus0.ifid_pc4_o, 32'h0);
        step(0, 0, 0);
        check("rs_next_addr", bus0.imem_addr_o, 32'h104);

        // Stall right after reset keeps IF/ID empty.
        apply_reset();
        step(1, 0, 0);
        check("fill_stall_addr", bus0.imem_addr_o, 32'h0);
        check("fill_stall_valid", {31'b0, bus0.ifid_valid_o}, 32'h0);
        step(0, 0, 0);
        check("fill_run_addr", bus0.imem_addr_o, 32'h4);

        // Reset while stalled, then while a redirect is pending.
        stall = 1'b1;
        apply_reset();
        check("mid_stall_addr", bus0.imem_addr_o, 32'h0);
        stall = 1'b0; redirect = 1'b1; target = 32'h80;
        apply_reset();
        step(0, 0, 0);
        check("mid_redir_addr", bus0.imem_addr_o, 32'h4);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(99) < 2) begin
                stall = $urandom_range(1); redirect = $urandom_range(1);
                apply_reset();
            end
            step($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
